// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- RV32I integer ALU with a registered result, for the single-cycle
// RISC-V datapath. It sits between the operand muxes and the
// writeback/branch unit.
//
// Ports
//   clk       : clock; all state updates on the rising edge
//   rst_n     : asynchronous active-low reset
//   A, B      : operands (rs1, rs2/immediate)
//   ALUop     : {funct7[5], funct3} operation select
//   in_valid  : operands/op valid this cycle
//   ALUS      : registered result (signed view)
//   zero      : registered, 1 when the captured result is 0
//   out_valid : in_valid delayed by one cycle
// ---------------------------------------------------------------------------
module alu #(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        A,
    input  logic [WIDTH-1:0]        B,
    input  logic [3:0]              ALUop,
    input  logic                    in_valid,
    output logic signed [WIDTH-1:0] ALUS,
    output logic                    zero,
    output logic                    out_valid
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b1000,
        OP_SLL  = 4'b0001,
        OP_SLT  = 4'b0010,
        OP_SLTU = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SRA  = 4'b1101,
        OP_OR   = 4'b0110,
        OP_AND  = 4'b0111
    } alu_op_e;

    // Only the low bits of B select the shift; upper bits are ignored.
    logic [SHW-1:0]          shamt;
    logic signed [WIDTH-1:0] sra_res;
    logic [WIDTH-1:0]        result;

    assign shamt   = B[SHW-1:0];
    assign sra_res = $signed(A) >>> shamt;

    always_comb begin
        result = '0;
        case (ALUop)
            OP_ADD:  result = A + B;
            OP_SUB:  result = A - B;
            OP_SLL:  result = A << shamt;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_XOR:  result = A ^ B;
            OP_SRL:  result = A >> shamt;
            OP_SRA:  result = sra_res;
            OP_OR:   result = A | B;
            OP_AND:  result = A & B;
            // Unused encodings quietly produce 0.
            default: result = '0;
        endcase
    end

    // zero is derived from the value being captured so it always tracks ALUS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUS      <= '0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                ALUS <= result;
                zero <= (result == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- scoreboard bench for alu. The driver pushes the hand-computed
// expected result for each valid op; a monitor pops and compares whenever
// out_valid is seen, and also checks out_valid against the one-cycle-delayed
// in_valid that was driven.
// ---------------------------------------------------------------------------
module tb_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] A, B;
    logic [3:0]  ALUop;
    logic        in_valid;
    logic signed [31:0] ALUS;
    logic        zero;
    logic        out_valid;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        z;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .ALUop(ALUop),
        .in_valid(in_valid), .ALUS(ALUS), .zero(zero), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Monitor: sample 1 time unit after the rising edge.
    always @(posedge clk) begin
        logic v;
        v = in_valid && rst_n;
        #1;
        if (rst_n) begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, v});
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk({e.name, ".ALUS"}, ALUS, e.res);
                    chk({e.name, ".zero"}, {31'b0, zero}, {31'b0, e.z});
                end
            end
        end
    end

    task automatic op(input string nm, input logic [3:0] o,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] e);
        exp_t x;
        @(negedge clk);
        A = a; B = b; ALUop = o; in_valid = 1'b1;
        x.name = nm; x.res = e; x.z = (e == 32'd0);
        q.push_back(x);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        A = 32'hDEAD_BEEF; B = 32'h1; ALUop = 4'b0000;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; ALUop = '0;
        #3;
        chk("reset.ALUS", ALUS, 32'd0);
        chk("reset.zero", {31'b0, zero}, 32'd0);
        chk("reset.out_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        op("add_1_2",    4'b0000, 32'd1,         32'd2,         32'd3);
        op("add_wrap",   4'b0000, 32'hFFFF_FFFF, 32'd1,         32'd0);
        op("sub_4_2",    4'b1000, 32'd4,         32'd2,         32'd2);
        op("sub_2_4",    4'b1000, 32'd2,         32'd4,         32'hFFFF_FFFE);
        op("xor",        4'b0100, 32'd1,         32'd3,         32'd2);
        op("or",         4'b0110, 32'd1,         32'd2,         32'd3);
        op("and",        4'b0111, 32'd1,         32'd2,         32'd0);
        op("sll",        4'b0001, 32'd1,         32'd2,         32'd4);
        op("srl",        4'b0101, 32'h20,        32'd5,         32'd1);
        op("sra",        4'b1101, 32'h8000_0000, 32'd4,         32'hF800_0000);
        op("srl_bhi",    4'b0101, 32'h8000_0000, 32'h24,        32'h0800_0000);
        op("sra_bhi",    4'b1101, 32'h8000_0001, 32'h21,        32'hC000_0000);
        op("slt_3_2",    4'b0010, 32'd3,         32'd2,         32'd0);
        op("slt_neg",    4'b0010, 32'hFFFF_FFFF, 32'd1,         32'd1);
        op("sltu_big",   4'b0011, 32'hFFFF_FFFF, 32'd1,         32'd0);
        op("sltu_3_2",   4'b0011, 32'd3,         32'd2,         32'd0);
        op("sltu_lt",    4'b0011, 32'd1,         32'hFFFF_FFFF, 32'd1);
        op("unused_f",   4'b1111, 32'd5,         32'd5,         32'd0);
        op("unused_9",   4'b1001, 32'd7,         32'd3,         32'd0);
        op("sll_sh0",    4'b0001, 32'h1234,      32'h20,        32'h1234);

        // Hold: idle cycles with junk operands must not disturb ALUS/zero.
        idle();
        @(posedge clk); #2;
        chk("hold.ALUS", ALUS, 32'h1234);
        chk("hold.zero", {31'b0, zero}, 32'd0);
        idle();
        @(posedge clk); #2;
        chk("hold2.ALUS", ALUS, 32'h1234);

        // Mid-operation reset: the in-flight op is discarded and outputs
        // clear without any clock edge.
        op("inflight", 4'b0000, 32'd5, 32'd6, 32'd11);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("async_rst.ALUS", ALUS, 32'd0);
        chk("async_rst.zero", {31'b0, zero}, 32'd0);
        chk("async_rst.out_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        A = 32'd7; B = 32'd8; ALUop = 4'b0000; in_valid = 1'b1;
        begin
            exp_t x;
            x.name = "post_rst_add"; x.res = 32'd15; x.z = 1'b0;
            q.push_back(x);
        end
        idle();
        idle();
        idle();

        chk("scoreboard_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #20000;
        errors++;
        $display("FAIL watchdog: timeout reached, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
